tile_sched: RTL and testbench

- Consumer of calc_tile_n. It takes the layer configuration and the computed tile_n (rows per GLB-resident tile).
- It walks every tile of the layer and emits one tile descriptor per tile over a valid/ready handshake. The descriptors feed the DMA and PE-array controllers.
- It runs between the layer-config registers and the tile-level datapath controllers, one layer per start.

---
 rtl/tile_pkg.sv | 33 +++
 rtl/tile_len_clamp.sv | 26 ++
 rtl/tile_sched.sv | 161 ++++++++++++++++
 tb/tb_tile_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// tile_pkg: shared types for the tile scheduler.
//   - layer-type codes (pointwise / depthwise / standard)
//   - state_t: scheduler FSM states
//   - tile_desc_t: one tile descriptor as seen by the DMA / PE-array controllers
//     (field widths follow the default CH_W=7, ROW_W=8 build)
package tile_pkg;

  localparam logic [1:0] LT_POINTWISE = 2'd0;
  localparam logic [1:0] LT_DEPTHWISE = 2'd1;
  localparam logic [1:0] LT_STANDARD  = 2'd2;

  localparam int DESC_CH_W  = 7;
  localparam int DESC_ROW_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [DESC_CH_W-1:0]  k_start;
    logic [DESC_CH_W-1:0]  k_len;
    logic [DESC_CH_W-1:0]  d_start;
    logic [DESC_CH_W-1:0]  d_len;
    logic [DESC_ROW_W-1:0] r_start;
    logic [DESC_ROW_W-1:0] r_len;
    logic                  first_d;
    logic                  last_d;
  } tile_desc_t;

endpackage

// File: rtl/tile_len_clamp.sv
// tile_len_clamp: length of one tile along a single loop dimension.
//   start : first index of the tile
//   step  : nominal tile size
//   total : extent of the dimension
//   len   : min(step, total - start)   (tail tiles are clamped)
//   last  : this tile reaches the end of the dimension (start + len == total)
// The end test is done one bit wider so it cannot wrap at the top of the range.
module tile_len_clamp #(
  parameter int W = 7
) (
  input  logic [W-1:0] start,
  input  logic [W-1:0] step,
  input  logic [W-1:0] total,
  output logic [W-1:0] len,
  output logic         last
);

  logic [W-1:0] remain;
  logic [W:0]   tile_end;

  assign remain   = total - start;
  assign len      = (step < remain) ? step : remain;
  assign tile_end = {1'b0, start} + {1'b0, len};
  assign last     = (tile_end == {1'b0, total});

endmodule

// File: rtl/tile_sched.sv
// tile_sched: walks every tile of one layer and emits one descriptor per tile.
// Loop order is k (output channels) outer, d (input channels) middle, r (rows)
// inner. Depthwise layers collapse the d loop onto k.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin a layer (ignored while busy) / cancel it
//   layer_type, in_C, out_C, tile_D, tile_K, in_R, tile_n   layer config
//   desc_valid/desc_ready descriptor handshake
//   k_*, d_*, r_*         descriptor fields (0 when desc_valid is low)
//   first_d, last_d       psum init / writeback markers
//   busy, done, err       status: in progress, end-of-layer pulse, bad config
module tile_sched
  import tile_pkg::*;
#(
  parameter int CH_W  = 7,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       layer_type,
  input  logic [CH_W-1:0]  in_C,
  input  logic [CH_W-1:0]  out_C,
  input  logic [CH_W-1:0]  tile_D,
  input  logic [CH_W-1:0]  tile_K,
  input  logic [ROW_W-1:0] in_R,
  input  logic [31:0]      tile_n,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [CH_W-1:0]  k_start,
  output logic [CH_W-1:0]  k_len,
  output logic [CH_W-1:0]  d_start,
  output logic [CH_W-1:0]  d_len,
  output logic [ROW_W-1:0] r_start,
  output logic [ROW_W-1:0] r_len,
  output logic             first_d,
  output logic             last_d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  function automatic logic [ROW_W-1:0] sat_rows(input logic [31:0] n);
    logic [31:0] max_v;
    max_v = (32'd1 << ROW_W) - 32'd1;
    if (n > max_v) return '1;
    else           return n[ROW_W-1:0];
  endfunction

  state_t state, state_nx;

  logic             dw_q;
  logic [CH_W-1:0]  in_c_q, out_c_q, tile_d_q, tile_k_q;
  logic [ROW_W-1:0] in_r_q, tn_q;
  logic [CH_W-1:0]  k_cnt, d_cnt;
  logic [ROW_W-1:0] r_cnt;
  logic             err_q;

  logic [CH_W-1:0]  k_len_w, d_len_w;
  logic [ROW_W-1:0] r_len_w;
  logic             k_last, d_last, r_last, d_last_eff, tile_last;
  logic             cfg_bad, hs;

  tile_len_clamp #(.W(CH_W)) u_k_clamp (
    .start(k_cnt), .step(tile_k_q), .total(out_c_q), .len(k_len_w), .last(k_last)
  );
  tile_len_clamp #(.W(CH_W)) u_d_clamp (
    .start(d_cnt), .step(tile_d_q), .total(in_c_q), .len(d_len_w), .last(d_last)
  );
  tile_len_clamp #(.W(ROW_W)) u_r_clamp (
    .start(r_cnt), .step(tn_q), .total(in_r_q), .len(r_len_w), .last(r_last)
  );

  // Depthwise: the d loop is the k loop, so it always "ends" with each k step.
  assign d_last_eff = dw_q | d_last;
  assign tile_last  = r_last & d_last_eff & k_last;

  // Checked on the live config during LOAD, the same cycle it is latched.
  assign cfg_bad = (tile_n == 32'd0) | (tile_D == '0) | (tile_K == '0) |
                   (in_C == '0) | (out_C == '0) | (in_R == '0);

  // abort outranks a handshake in the same cycle.
  assign hs = (state == S_EMIT) & desc_ready & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    desc_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = cfg_bad ? S_DONE : S_EMIT;
      S_EMIT: begin
        desc_valid = 1'b1;
        if (desc_ready && tile_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  // Config and loop counters: only meaningful in EMIT, where they were
  // initialised by LOAD, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      dw_q     <= (layer_type == LT_DEPTHWISE);
      in_c_q   <= in_C;
      out_c_q  <= out_C;
      tile_d_q <= tile_D;
      tile_k_q <= tile_K;
      in_r_q   <= in_R;
      tn_q     <= sat_rows(tile_n);
      k_cnt    <= '0;
      d_cnt    <= '0;
      r_cnt    <= '0;
    end else if (hs) begin
      // A non-last tile has len == step, so start+len is the next start.
      if (!r_last) begin
        r_cnt <= r_cnt + r_len_w;
      end else begin
        r_cnt <= '0;
        if (!d_last_eff) begin
          d_cnt <= d_cnt + d_len_w;
        end else begin
          d_cnt <= '0;
          if (!k_last) k_cnt <= k_cnt + k_len_w;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_q <= 1'b0;
    else if (state == S_IDLE && start)             err_q <= 1'b0;
    else if (state == S_LOAD && cfg_bad && !abort) err_q <= 1'b1;
  end

  assign err     = err_q;
  assign k_start = desc_valid ? k_cnt   : '0;
  assign k_len   = desc_valid ? k_len_w : '0;
  assign d_start = desc_valid ? (dw_q ? k_cnt   : d_cnt)   : '0;
  assign d_len   = desc_valid ? (dw_q ? k_len_w : d_len_w) : '0;
  assign r_start = desc_valid ? r_cnt   : '0;
  assign r_len   = desc_valid ? r_len_w : '0;
  assign first_d = desc_valid & (dw_q | (d_cnt == '0));
  assign last_d  = desc_valid & d_last_eff;

endmodule

// File: tb/tb_tile_sched.sv
// Bench for tile_sched: a loop-nest model builds the expected descriptor list
// for each layer; a monitor compares every accepted descriptor against it,
// checks hold-while-stalled and the done pulse after the final descriptor.
module tb_tile_sched;
  import tile_pkg::*;

  localparam int CH_W  = 7;
  localparam int ROW_W = 8;

  logic             clk, rst_n, start, abort, desc_ready;
  logic [1:0]       layer_type;
  logic [CH_W-1:0]  in_C, out_C, tile_D, tile_K;
  logic [ROW_W-1:0] in_R;
  logic [31:0]      tile_n;
  logic             desc_valid, first_d, last_d, busy, done, err;
  logic [CH_W-1:0]  k_start, k_len, d_start, d_len;
  logic [ROW_W-1:0] r_start, r_len;

  tile_sched #(.CH_W(CH_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_type(layer_type), .in_C(in_C), .out_C(out_C), .tile_D(tile_D),
    .tile_K(tile_K), .in_R(in_R), .tile_n(tile_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .k_start(k_start), .k_len(k_len), .d_start(d_start), .d_len(d_len),
    .r_start(r_start), .r_len(r_len), .first_d(first_d), .last_d(last_d),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  tile_desc_t exp_q[$];
  int         exp_total;

  task automatic build_model(input logic [1:0] lt, input int ic, input int oc,
                             input int td, input int tk, input int ir, input int tn);
    tile_desc_t t;
    int kl, dl, rl;
    exp_q.delete();
    if (tn > 255) tn = 255;
    for (int k = 0; k < oc; k += tk) begin
      kl = (tk < oc - k) ? tk : oc - k;
      for (int d = 0; d < ((lt == LT_DEPTHWISE) ? 1 : ic); d += td) begin
        dl = (td < ic - d) ? td : ic - d;
        for (int r = 0; r < ir; r += tn) begin
          rl = (tn < ir - r) ? tn : ir - r;
          t.k_start = 7'(k); t.k_len = 7'(kl);
          t.r_start = 8'(r); t.r_len = 8'(rl);
          if (lt == LT_DEPTHWISE) begin
            t.d_start = 7'(k); t.d_len = 7'(kl);
            t.first_d = 1'b1;  t.last_d = 1'b1;
          end else begin
            t.d_start = 7'(d); t.d_len = 7'(dl);
            t.first_d = (d == 0); t.last_d = (d + dl == ic);
          end
          exp_q.push_back(t);
        end
      end
    end
    exp_total = exp_q.size();
  endtask

  // ---------------- monitor ----------------
  bit         mon_en = 1'b0;
  bit         exp_done, stall_prev;
  int         hs_cnt;
  tile_desc_t held, cur;

  always @(negedge clk) begin
    if (mon_en) begin
      cur = tile_desc_t'{k_start, k_len, d_start, d_len, r_start, r_len, first_d, last_d};
      if (exp_done) begin
        chk("done_after_last", done, 1'b1);
        chk("valid_in_done", desc_valid, 1'b0);
        exp_done = 1'b0;
      end else if (done) begin
        chk("spurious_done", done, 1'b0);
      end
      if (stall_prev) begin
        chk("stall_valid", desc_valid, 1'b1);
        chk("stall_hold", cur, held);
      end
      stall_prev = 1'b0;
      if (desc_valid && !abort) begin
        if (desc_ready) begin
          if (exp_q.size() == 0) begin
            chk("desc_count", hs_cnt + 1, exp_total);
          end else begin
            chk("desc", cur, exp_q.pop_front());
            hs_cnt++;
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end else begin
          stall_prev = 1'b1;
          held       = cur;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input logic [1:0] lt, input int ic, input int oc,
                     input int td, input int tk, input int ir, input int tn);
    layer_type = lt; in_C = 7'(ic); out_C = 7'(oc); tile_D = 7'(td);
    tile_K = 7'(tk); in_R = 8'(ir); tile_n = 32'(tn);
  endtask

  task automatic arm_monitor();
    hs_cnt = 0; exp_done = 1'b0; stall_prev = 1'b0; mon_en = 1'b1;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1; desc_ready = 1'b0;
    @(negedge clk);
    chk("start_cycle_valid", desc_valid, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("load_busy", busy, 1'b1);
    chk("load_valid", desc_valid, 1'b0);
    chk("load_err_clear", err, 1'b0);
  endtask

  task automatic run_layer(input bit rnd, input int mid_start, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      desc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = (n == mid_start);
      n++;
      @(negedge clk);
      if (n == 1) chk("latency_valid", desc_valid, 1'b1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    #1;
    chk("layer_done_seen", seen, 1'b1);
    chk("desc_total", hs_cnt, exp_total);
    chk("model_drained", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {desc_valid, k_start, k_len, d_start, d_len, r_start, r_len,
            first_d, last_d, busy, done, err};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int nl, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; desc_ready = 1'b0;
    cfg(LT_POINTWISE, 112, 112, 32, 32, 16, 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // Pointwise 112/112, 32/32, rows 16 by 10
    build_model(LT_POINTWISE, 112, 112, 32, 32, 16, 10);
    chk("pw_model_n", exp_q.size(), 32);
    chk("pw_model_first", exp_q[0], tile_desc_t'{7'd0, 7'd32, 7'd0, 7'd32, 8'd0, 8'd10, 1'b1, 1'b0});
    chk("pw_model_last", exp_q[31], tile_desc_t'{7'd96, 7'd16, 7'd96, 7'd16, 8'd10, 8'd6, 1'b0, 1'b1});
    arm_monitor();
    do_start();
    run_layer(1'b0, -1, 200);

    // Depthwise 112 channels by 10, rows 8 by 4, start pulsed mid-layer
    cfg(LT_DEPTHWISE, 112, 112, 32, 10, 8, 4);
    build_model(LT_DEPTHWISE, 112, 112, 32, 10, 8, 4);
    chk("dw_model_n", exp_q.size(), 24);
    chk("dw_model_last", exp_q[23], tile_desc_t'{7'd110, 7'd2, 7'd110, 7'd2, 8'd4, 8'd4, 1'b1, 1'b1});
    arm_monitor();
    do_start();
    run_layer(1'b0, 5, 200);

    // Standard 64/64, 10/10, rows 10 by 5, random ready
    cfg(LT_STANDARD, 64, 64, 10, 10, 10, 5);
    build_model(LT_STANDARD, 64, 64, 10, 10, 10, 5);
    chk("std_model_n", exp_q.size(), 98);
    nl = 0;
    foreach (exp_q[i]) if (exp_q[i].last_d && exp_q[i].d_start == 7'd60 && exp_q[i].d_len == 7'd4) nl++;
    chk("std_model_lastd", nl, 14);
    arm_monitor();
    do_start();
    run_layer(1'b1, -1, 2000);

    // Config error: tile_n == 0
    cfg(LT_POINTWISE, 16, 16, 8, 8, 8, 0);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); chk("err_t0_busy", busy, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("err_load_done", done, 1'b0); chk("err_load_valid", desc_valid, 1'b0);
    @(negedge clk);
    chk("err_done", done, 1'b1); chk("err_flag", err, 1'b1); chk("err_no_desc", desc_valid, 1'b0);
    @(negedge clk);
    chk("err_done_clear", done, 1'b0); chk("err_held", err, 1'b1); chk("err_idle", busy, 1'b0);

    // tile_n above the row range saturates; one row block of 8
    cfg(LT_POINTWISE, 8, 8, 8, 8, 8, 1000);
    build_model(LT_POINTWISE, 8, 8, 8, 8, 8, 1000);
    chk("sat_model_n", exp_q.size(), 1);
    chk("sat_model_rlen", exp_q[0].r_len, 8'd8);
    arm_monitor();
    do_start();
    run_layer(1'b0, -1, 50);
    chk("sat_err_clear", err, 1'b0);

    // Abort after the 5th handshake (ready high in the abort cycle)
    cfg(LT_POINTWISE, 112, 112, 32, 32, 16, 10);
    build_model(LT_POINTWISE, 112, 112, 32, 32, 16, 10);
    arm_monitor();
    do_start();
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      @(posedge clk); #1 desc_ready = 1'b1;
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reach5", hs_cnt, 5);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk); chk("abort_cycle_valid", desc_valid, 1'b1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", desc_valid, 1'b0); chk("abort_busy", busy, 1'b0); chk("abort_no_done", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_hs", hs_cnt, 5);
    mon_en = 1'b0;

    // Asynchronous reset mid-EMIT
    desc_ready = 1'b0;
    do_start();
    @(posedge clk); #2;
    chk("pre_reset_valid", desc_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
